// File: rtl/sram_wb_arbiter.sv
// sram_wb_arbiter
//   Two-master, one-slave Wishbone arbiter in front of the shared SSRAM
//   controller. Master 0 is instruction fetch and master 1 is load/store.
//   Grants are round-robin and registered. A grant is held for the whole bus
//   cycle (CYC high), so bursts and read-modify-write sequences are never
//   split. After a release the arbiter spends one idle cycle before it
//   grants again.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   m0_* / m1_*           master-side Wishbone classic interfaces
//   s_*                   slave-side Wishbone classic interface
//   gnt_o                 one-hot current grant {m1, m0}; 00 when idle
//
// Optional feature
//   SRAM_ARB_TIMEOUT_EN   when defined, a watchdog aborts a granted cycle
//                         after TIMEOUT_CYCLES consecutive STB-without-ACK
//                         cycles. It pulses mx_err_o for one cycle and
//                         releases the grant. When undefined, m*_err_o
//                         are tied to 0.

module sram_wb_arbiter #(
    parameter int AW             = 19,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,

    output logic [1:0]        gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    // Round-robin pointer: the master that held the bus most recently.
    logic   last_q, last_d;

    logic   cyc_raw;
    logic   stb_raw;
    logic   abort;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and grant pointer update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_d = last_q ? GNT0 : GNT1;
                else if (m0_cyc_i)
                    state_d = GNT0;
                else if (m1_cyc_i)
                    state_d = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i || abort) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i || abort) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Slave-side mux. All request fields are zeroed while idle, so a reset
    // (asynchronous to the clock) pulls the slave controls low at once.
    // ------------------------------------------------------------------
    always_comb begin
        cyc_raw = 1'b0;
        stb_raw = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        case (state_q)
            GNT0: begin
                cyc_raw = m0_cyc_i;
                stb_raw = m0_stb_i;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
            end
            GNT1: begin
                cyc_raw = m1_cyc_i;
                stb_raw = m1_stb_i;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
            end
            default: ;
        endcase
    end

    assign s_cyc_o  = cyc_raw & ~abort;
    assign s_stb_o  = stb_raw & ~abort;

    assign gnt_o    = {state_q == GNT1, state_q == GNT0};

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & (state_q == GNT0);
    assign m1_ack_o = s_ack_i & (state_q == GNT1);
    assign m0_err_o = abort & (state_q == GNT0);
    assign m1_err_o = abort & (state_q == GNT1);

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] LAST_STALL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;

    assign stall = stb_raw & ~s_ack_i;
    // The count holds the number of earlier stall cycles, so the abort fires
    // during the TIMEOUT_CYCLES-th stall cycle itself, not one cycle later.
    assign abort = stall && (cnt_q == LAST_STALL);

    always_comb begin
        cnt_d = cnt_q;
        if (state_d == IDLE || s_ack_i)
            cnt_d = '0;
        else if (stall)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    assign abort = 1'b0;

    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_sram_wb_arbiter.sv
module tb_sram_wb_arbiter;

    localparam int AW = 19;
    localparam int DW = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0]   m0_adr_i;
    logic [DW-1:0]   m0_dat_i;
    logic [DW/8-1:0] m0_sel_i;
    logic [DW-1:0]   m0_dat_o;
    logic            m0_ack_o, m0_err_o;
    logic            m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0]   m1_adr_i;
    logic [DW-1:0]   m1_dat_i;
    logic [DW/8-1:0] m1_sel_i;
    logic [DW-1:0]   m1_dat_o;
    logic            m1_ack_o, m1_err_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW/8-1:0] s_sel_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i;
    logic [1:0]      gnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    sram_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_dat_i = '0; s_ack_i = 0;
        tick(); tick();
        n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b want 00", gnt_o); end
        n_checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin n_fail++; $display("FAIL reset_sctl got %b want 000", {s_cyc_o, s_stb_o, s_we_o}); end
        n_checks++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_resp got %b want 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 19'h00010; m0_sel_i = 4'hF;
        #1;
        n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rd_latency s_cyc got %b want 0", s_cyc_o); end
        tick();
        n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL rd_gnt got %b want 01", gnt_o); end
        n_checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b110) begin n_fail++; $display("FAIL rd_sctl got %b want 110", {s_cyc_o, s_stb_o, s_we_o}); end
        n_checks++; if (s_adr_o !== 19'h00010) begin n_fail++; $display("FAIL rd_adr got %h want 00010", s_adr_o); end
        n_checks++; if (m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL rd_early_ack got %b want 0", m0_ack_o); end
        tick();
        tick();
        s_ack_i = 1; s_dat_i = 32'hCAFEF00D;
        #1;
        n_checks++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin n_fail++; $display("FAIL rd_ack got %b want 10", {m0_ack_o, m1_ack_o}); end
        n_checks++; if (m0_dat_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_dat got %h want cafef00d", m0_dat_o); end
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        #1;
        n_checks++; if ({m0_ack_o, m1_ack_o} !== 2'b00) begin n_fail++; $display("FAIL rd_ack_single got %b want 00", {m0_ack_o, m1_ack_o}); end
        tick();
        n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL rd_release got %b want 00", gnt_o); end
    endtask

    task automatic test_contention();
        #2 rst_i = 1; #2 rst_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 19'h00020;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 19'h00030; m1_we_i = 0; m1_sel_i = 4'hF;
        tick();
        n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL cont_first got %b want 01", gnt_o); end
        n_checks++; if (s_adr_o !== 19'h00020) begin n_fail++; $display("FAIL cont_adr0 got %h want 00020", s_adr_o); end
        s_ack_i = 1; #1;
        n_checks++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin n_fail++; $display("FAIL cont_ack0 got %b want 10", {m0_ack_o, m1_ack_o}); end
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        n_checks++; if ({gnt_o, s_cyc_o} !== 3'b000) begin n_fail++; $display("FAIL cont_dead gnt/cyc got %b want 000", {gnt_o, s_cyc_o}); end
        tick();
        n_checks++; if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL cont_second got %b want 10", gnt_o); end
        n_checks++; if ({s_cyc_o, s_adr_o} !== {1'b1, 19'h00030}) begin n_fail++; $display("FAIL cont_adr1 got %b/%h want 1/00030", s_cyc_o, s_adr_o); end
        s_ack_i = 1; #1;
        n_checks++; if ({m0_ack_o, m1_ack_o} !== 2'b01) begin n_fail++; $display("FAIL cont_ack1 got %b want 01", {m0_ack_o, m1_ack_o}); end
        tick();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL cont_alternate got %b want 01", gnt_o); end
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 19'h00100; m1_sel_i = 4'hF; m1_dat_i = 32'h1000;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 19'h00055;
        for (int i = 0; i < 4; i++) begin
            m1_adr_i = 19'h00100 + 19'(i);
            m1_dat_i = 32'h1000 + 32'(i);
            s_ack_i = 1;
            #1;
            n_checks++; if ({gnt_o, s_we_o, s_sel_o} !== {2'b10, 1'b1, 4'hF}) begin n_fail++; $display("FAIL burst_ctl beat %0d got %b want 1011111", i, {gnt_o, s_we_o, s_sel_o}); end
            n_checks++; if (s_adr_o !== 19'h00100 + 19'(i)) begin n_fail++; $display("FAIL burst_adr beat %0d got %h want %h", i, s_adr_o, 19'h00100 + 19'(i)); end
            n_checks++; if (s_dat_o !== 32'h1000 + 32'(i)) begin n_fail++; $display("FAIL burst_dat beat %0d got %h want %h", i, s_dat_o, 32'h1000 + 32'(i)); end
            n_checks++; if ({m0_ack_o, m1_ack_o} !== 2'b01) begin n_fail++; $display("FAIL burst_ack beat %0d got %b want 01", i, {m0_ack_o, m1_ack_o}); end
            tick();
        end
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        #1;
        n_checks++; if ({gnt_o, s_cyc_o} !== 3'b100) begin n_fail++; $display("FAIL burst_tail got %b want 100", {gnt_o, s_cyc_o}); end
        tick();
        n_checks++; if ({gnt_o, s_cyc_o} !== 3'b000) begin n_fail++; $display("FAIL burst_dead got %b want 000", {gnt_o, s_cyc_o}); end
        tick();
        n_checks++; if ({gnt_o, s_adr_o} !== {2'b01, 19'h00055}) begin n_fail++; $display("FAIL burst_m0_after got %b/%h want 01/00055", gnt_o, s_adr_o); end
        m0_cyc_i = 0; m0_stb_i = 0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_cycle();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 19'h00200;
        tick(); tick();
        n_checks++; if ({gnt_o, s_stb_o} !== 3'b101) begin n_fail++; $display("FAIL mid_pre got %b want 101", {gnt_o, s_stb_o}); end
        rst_i = 1;
        #1;
        n_checks++; if ({gnt_o, s_cyc_o, s_stb_o} !== 4'b0000) begin n_fail++; $display("FAIL mid_async got %b want 0000", {gnt_o, s_cyc_o, s_stb_o}); end
        #1 rst_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL mid_rr_reset got %b want 01", gnt_o); end
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick(); tick();
    endtask

    task automatic test_timeout();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 19'h00300;
        tick();
        m1_cyc_i = 1; m1_stb_i = 1;
`ifdef SRAM_ARB_TIMEOUT_EN
        for (int k = 1; k < 8; k++) begin
            n_checks++; if ({m0_err_o, s_cyc_o, gnt_o} !== 4'b0101) begin n_fail++; $display("FAIL to_stall %0d got %b want 0101", k, {m0_err_o, s_cyc_o, gnt_o}); end
            tick();
        end
        n_checks++; if ({m0_err_o, m1_err_o, s_cyc_o, s_stb_o} !== 4'b1000) begin n_fail++; $display("FAIL to_abort got %b want 1000", {m0_err_o, m1_err_o, s_cyc_o, s_stb_o}); end
        tick();
        n_checks++; if ({m0_err_o, gnt_o} !== 3'b000) begin n_fail++; $display("FAIL to_idle got %b want 000", {m0_err_o, gnt_o}); end
        tick();
        n_checks++; if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL to_m1_grant got %b want 10", gnt_o); end
`else
        for (int k = 1; k <= 20; k++) begin
            n_checks++; if ({m0_err_o, m1_err_o, s_cyc_o, gnt_o} !== 5'b00101) begin n_fail++; $display("FAIL to_held %0d got %b want 00101", k, {m0_err_o, m1_err_o, s_cyc_o, gnt_o}); end
            tick();
        end
`endif
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick(); tick(); tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_reset_mid_cycle();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_wb_arbiter.md
Name: sram_wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter in front of the shared SSRAM controller inside cpu_top.
- Master 0 is instruction fetch; master 1 is the data/load-store port.
- Grants are round-robin and registered. A grant is held for the whole bus cycle (CYC high), so burst and read-modify-write sequences are never split.
- An optional watchdog terminates hung slave cycles with an error.

Parameters:
- AW, 19, address width in 32-bit words; matches the SSRAM address bus.
- DW, 32, data width; byte selects are DW/8 bits wide.
- TIMEOUT_CYCLES, 255, STB-without-ACK cycles before abort. Used only with the optional feature.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls.
- m0_adr_i  in  AW  master 0 address.
- m0_dat_i  in  DW  master 0 write data.
- m0_sel_i  in  DW/8  master 0 byte selects.
- m0_dat_o  out  DW  master 0 read data.
- m0_ack_o  out  1  master 0 acknowledge.
- m0_err_o  out  1  master 0 error / timeout.
- m1_*  same set as m0_*  master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave acknowledge.
- gnt_o  out  2  one-hot current grant, for debug and the performance counter.

Behaviour:
- States: IDLE, GNT0, GNT1. Reset enters IDLE.
- Reset values:
  - gnt_o = 2'b00.
  - All s_* control outputs = 0.
  - All m*_ack_o and m*_err_o = 0.
  - Round-robin pointer last = 1, so master 0 wins the first contention.
- IDLE transitions:
  - Only m0_cyc_i high -> GNT0.
  - Only m1_cyc_i high -> GNT1.
  - Both high -> grant the master that is not `last`.
  - Neither high -> stay in IDLE.
- Grant latency: the grant registers on the edge after the request is seen. Slave signals appear in the following cycle, i.e. at least 1 cycle from CYC to s_cyc_o.
- GNTx outputs:
  - s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o are combinationally muxed from master x.
  - s_cyc_o and s_stb_o are gated by the grant; in IDLE they are forced to 0.
- Response routing:
  - s_dat_i is broadcast to m0_dat_o and m1_dat_o.
  - mx_ack_o = s_ack_i AND grant x. The non-granted ack is always 0.
- Release: when the granted mx_cyc_i is sampled low, go to IDLE and set last = x.
  - Re-arbitration takes one dead cycle, so back-to-back cycles from different masters are separated by at least one idle slave cycle.
- Masters hold their requests (Wishbone classic); the arbiter never drops a pending request.
- Simultaneous events:
  - CYC dropping in the same cycle as s_ack_i: the ack is still forwarded and release happens on that edge.
  - An ack arriving in IDLE is ignored (not forwarded).
- Mid-cycle reset: state goes to IDLE immediately; s_cyc_o drops asynchronously; the slave is expected to be reset by the same rst_i.

Optional Feature:
- Macro: SRAM_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider counter ($clog2(TIMEOUT_CYCLES+1) bits) counts cycles in which s_stb_o=1 and s_ack_i=0.
  - The counter clears on any s_ack_i and on entering IDLE.
  - When the count reaches TIMEOUT_CYCLES, assert mx_err_o for exactly one cycle, force s_cyc_o=0 in that cycle, go to IDLE and set last = x.
  - A master that keeps CYC high after the error is re-arbitrated like a new request.
- When undefined: no counter is built; m0_err_o = m1_err_o = 0 constantly.

Test Plan:
- Reset, then m0 single read at adr 0x00010 with the slave acking 2 cycles after stb -> gnt_o=01, s_adr_o=0x00010, m0_ack_o pulses once, m1_ack_o stays 0, return to IDLE.
- m0 and m1 raise CYC in the same cycle after reset -> m0 is granted first. After m0 drops CYC, exactly one idle cycle, then gnt_o=10. Next simultaneous contention grants m0 again (alternation).
- m1 holds CYC for a 4-beat write burst (adr 0x100..0x103, sel 4'hF) while m0 requests -> no s_adr_o change to m0 until all 4 m1 acks are seen and m1 CYC drops.
- rst_i asserted while in GNT1 with s_stb_o high -> s_cyc_o=0 and gnt_o=00 before the next clock edge; after release, the first contention is won by m0.
- With SRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, m0 stb with no slave ack -> m0_err_o high for one cycle on the 8th stall cycle, s_cyc_o low, a pending m1 is granted 2 cycles later. Without the macro the same stimulus leaves the grant held indefinitely and err_o=0.
